// File: rtl/issue_pkg.sv
// Shared definitions for the issue unit: entry and forward-bus field offsets, opcodes, and the ALU.
// The package is imported by issue_unit and operand_bypass.
package issue_pkg;

  localparam int NUM_FWD = 4;
  localparam int ENTRY_W = 57;
  localparam int FWD_W   = 23;
  localparam int DATA_W  = 16;
  localparam int ROB_W   = 6;
  localparam int OP_W    = 4;

  // Queue entry field offsets (LSB positions).
  localparam int E_V   = 56;
  localparam int E_OP  = 52;
  localparam int E_ROB = 46;
  localparam int E_LKA = 40;
  localparam int E_LKB = 34;
  localparam int E_VLA = 18;
  localparam int E_VLB = 2;
  localparam int E_PA  = 1;
  localparam int E_PB  = 0;

  // Forward bus field offsets.
  localparam int F_V   = 22;
  localparam int F_ROB = 16;
  localparam int F_VAL = 0;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_AND = 4'd2;
  localparam op_t OP_OR  = 4'd3;
  localparam op_t OP_XOR = 4'd4;
  localparam op_t OP_SHL = 4'd5;
  localparam op_t OP_SHR = 4'd6;
  localparam op_t OP_MOV = 4'd7;

  typedef struct packed {
    logic              vld;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] val;
  } fwd_t;

  // Undefined opcodes still produce a result so the ROB can retire them.
  function automatic logic [DATA_W-1:0] alu_eval(input op_t op, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << b[3:0];
      OP_SHR:  r = a >> b[3:0];
      OP_MOV:  r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// One operand's readiness and value: pending bit plus 4-way forward tag match (fwd[0] highest priority).
// Combinational. Forward matching only exists when ISSUE_FWD_BYPASS_EN is defined.
module operand_bypass
  import issue_pkg::*;
(
  input  logic                  i_pending,
  input  logic [ROB_W-1:0]      i_look,
  input  logic [DATA_W-1:0]     i_val,
  input  fwd_t [NUM_FWD-1:0]    i_fwd,
  output logic                  o_ready,
  output logic [DATA_W-1:0]     o_value
);

`ifdef ISSUE_FWD_BYPASS_EN
  // Scan from lowest to highest priority so the highest-priority match is written last.
  always_comb begin
    o_ready = !i_pending;
    o_value = i_val;
    if (i_pending) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (i_fwd[i].vld && (i_fwd[i].rob == i_look)) begin
          o_ready = 1'b1;
          o_value = i_fwd[i].val;
        end
      end
    end
  end
`else
  logic w_unused;

  assign o_ready  = !i_pending;
  assign o_value  = i_val;
  assign w_unused = ^{i_look, i_fwd};
`endif

endmodule

// File: rtl/issue_unit.sv
// In-order dual issue from the two queue heads to 1-cycle ALU lanes; results registered (1 cycle).
// No issue under stall/flush/reset; optional forward bypass enabled by ISSUE_FWD_BYPASS_EN.
module issue_unit
  import issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic [ENTRY_W-1:0] i_head0,
  input  logic [ENTRY_W-1:0] i_head1,
  input  logic [FWD_W-1:0]   i_fwdA,
  input  logic [FWD_W-1:0]   i_fwdB,
  input  logic [FWD_W-1:0]   i_fwdC,
  input  logic [FWD_W-1:0]   i_fwdD,
  output logic [1:0]         o_taken,
  output logic [FWD_W-1:0]   o_resultA,
  output logic [FWD_W-1:0]   o_resultB,
  output logic [CNT_W-1:0]   o_issueCount
);

  fwd_t [NUM_FWD-1:0] w_fwd;
  logic               w_rdy_a0, w_rdy_b0, w_rdy_a1, w_rdy_b1;
  logic [DATA_W-1:0]  w_val_a0, w_val_b0, w_val_a1, w_val_b1;
  logic               w_dep1;
  logic               w_issue0, w_issue1;
  logic [DATA_W-1:0]  w_alu0, w_alu1;
  logic [CNT_W:0]     w_cnt_sum;

  logic [FWD_W-1:0]   r_resultA, r_resultB;
  logic [CNT_W-1:0]   r_issue_count;

  assign w_fwd[0] = i_fwdA;
  assign w_fwd[1] = i_fwdB;
  assign w_fwd[2] = i_fwdC;
  assign w_fwd[3] = i_fwdD;

  operand_bypass u_a0 (
    .i_pending (i_head0[E_PA]),
    .i_look    (i_head0[E_LKA +: ROB_W]),
    .i_val     (i_head0[E_VLA +: DATA_W]),
    .i_fwd     (w_fwd),
    .o_ready   (w_rdy_a0),
    .o_value   (w_val_a0)
  );

  operand_bypass u_b0 (
    .i_pending (i_head0[E_PB]),
    .i_look    (i_head0[E_LKB +: ROB_W]),
    .i_val     (i_head0[E_VLB +: DATA_W]),
    .i_fwd     (w_fwd),
    .o_ready   (w_rdy_b0),
    .o_value   (w_val_b0)
  );

  operand_bypass u_a1 (
    .i_pending (i_head1[E_PA]),
    .i_look    (i_head1[E_LKA +: ROB_W]),
    .i_val     (i_head1[E_VLA +: DATA_W]),
    .i_fwd     (w_fwd),
    .o_ready   (w_rdy_a1),
    .o_value   (w_val_a1)
  );

  operand_bypass u_b1 (
    .i_pending (i_head1[E_PB]),
    .i_look    (i_head1[E_LKB +: ROB_W]),
    .i_val     (i_head1[E_VLB +: DATA_W]),
    .i_fwd     (w_fwd),
    .o_ready   (w_rdy_b1),
    .o_value   (w_val_b1)
  );

  // head1 waiting on head0's result cannot go this cycle: that value does not exist yet.
  assign w_dep1 = (i_head1[E_PA] && (i_head1[E_LKA +: ROB_W] == i_head0[E_ROB +: ROB_W])) ||
                  (i_head1[E_PB] && (i_head1[E_LKB +: ROB_W] == i_head0[E_ROB +: ROB_W]));

  assign w_issue0 = i_head0[E_V] && w_rdy_a0 && w_rdy_b0 && !i_stall && !i_flush && !i_reset;
  assign w_issue1 = w_issue0 && i_head1[E_V] && w_rdy_a1 && w_rdy_b1 && !w_dep1;

  assign o_taken = {1'b0, w_issue0} + {1'b0, w_issue1};

  assign w_alu0 = alu_eval(i_head0[E_OP +: OP_W], w_val_a0, w_val_b0);
  assign w_alu1 = alu_eval(i_head1[E_OP +: OP_W], w_val_a1, w_val_b1);

  assign w_cnt_sum = {1'b0, r_issue_count} + (CNT_W + 1)'(o_taken);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_resultA     <= '0;
      r_resultB     <= '0;
      r_issue_count <= '0;
    end else begin
      r_resultA     <= w_issue0 ? {1'b1, i_head0[E_ROB +: ROB_W], w_alu0} : '0;
      r_resultB     <= w_issue1 ? {1'b1, i_head1[E_ROB +: ROB_W], w_alu1} : '0;
      r_issue_count <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign o_resultA    = r_resultA;
  assign o_resultB    = r_resultB;
  assign o_issueCount = r_issue_count;

endmodule
